// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM state encoding and the latched request.
// Field widths match the default Bits/RegBits of mem_access_stage.
package mem_stage_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_stage_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              re;
        logic [RD_W-1:0]   rd;
    } mem_req_t;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// Result register toward WB: loads on capture, holds all fields stable while valid and
// not yet consumed.
module mem_stage_wb_reg #(
    parameter int Bits    = 16,
    parameter int RegBits = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               capture_i,
    input  logic [Bits-1:0]    data_i,
    input  logic [RegBits-1:0] rd_i,
    input  logic               is_load_i,
    input  logic               err_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [Bits-1:0]    data_o,
    output logic [RegBits-1:0] rd_o,
    output logic               is_load_o,
    output logic               err_o
);

    logic               valid_q;
    logic [Bits-1:0]    data_q;
    logic [RegBits-1:0] rd_q;
    logic               is_load_q;
    logic               err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            rd_q      <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (capture_i) begin
            valid_q   <= 1'b1;
            data_q    <= data_i;
            rd_q      <= rd_i;
            is_load_q <= is_load_i;
            err_q     <= err_i;
        end else if (valid_q && ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign rd_o      = rd_q;
    assign is_load_o = is_load_q;
    assign err_o     = err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage in front of Data_Memory: one-cycle memory access per request, registered result to WB.
// Optional MEM_STAGE_BOUNDS_CHECK_EN suppresses strobes for addr >= MemSize and flags wb_err_o.
//
// state  | meaning
// IDLE   | waiting for a request from EX, ex_ready_o high
// ACCESS | Data_Memory port driven from the request register for one cycle
// RESP   | result held toward WB until wb_ready_i
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int Bits    = DATA_W,
    parameter int MemSize = 256,
    parameter int RegBits = RD_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ex_valid_i,
    output logic               ex_ready_o,
    input  logic [Bits-1:0]    ex_addr_i,
    input  logic [Bits-1:0]    ex_wdata_i,
    input  logic               ex_we_i,
    input  logic               ex_re_i,
    input  logic [RegBits-1:0] ex_rd_i,
    output logic [Bits-1:0]    mem_access_addr_o,
    output logic [Bits-1:0]    mem_write_data_o,
    output logic               mem_write_en_o,
    output logic               mem_read_o,
    input  logic [Bits-1:0]    mem_read_data_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [Bits-1:0]    wb_data_o,
    output logic [RegBits-1:0] wb_rd_o,
    output logic               wb_is_load_o,
    output logic               wb_err_o
);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam logic [Bits:0] MEM_LIMIT = MemSize[Bits:0];

    mem_stage_state_t state_q;
    mem_req_t         req_q;
    logic             err_q;

    logic accept;
    logic oob;
    logic in_access;
    logic res_is_load;
    logic [Bits-1:0] res_data;

    assign ex_ready_o = (state_q == IDLE) || ((state_q == RESP) && wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o;
    assign oob        = CHECK_EN && ({1'b0, ex_addr_i} >= MEM_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{addr: ex_addr_i, wdata: ex_wdata_i, we: ex_we_i,
                           re: ex_re_i, rd: ex_rd_i};
                err_q <= oob;
            end
            unique case (state_q)
                IDLE:    if (accept) state_q <= ACCESS;
                ACCESS:  state_q <= RESP;
                RESP:    if (wb_ready_i) state_q <= accept ? ACCESS : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode only from registered state; rst kills a write already in flight.
    assign in_access         = (state_q == ACCESS) && !err_q;
    assign mem_write_en_o    = in_access && req_q.we && !rst_i;
    assign mem_read_o        = in_access && req_q.re && !req_q.we;
    assign mem_access_addr_o = req_q.addr;
    assign mem_write_data_o  = req_q.wdata;

    assign res_is_load = req_q.re && !req_q.we && !err_q;
    assign res_data    = res_is_load ? mem_read_data_i : '0;

    mem_stage_wb_reg #(
        .Bits    (Bits),
        .RegBits (RegBits)
    ) u_wb_reg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (state_q == ACCESS),
        .data_i    (res_data),
        .rd_i      (req_q.rd),
        .is_load_i (res_is_load),
        .err_i     (err_q),
        .ready_i   (wb_ready_i),
        .valid_o   (wb_valid_o),
        .data_o    (wb_data_o),
        .rd_o      (wb_rd_o),
        .is_load_o (wb_is_load_o),
        .err_o     (wb_err_o)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small Data_Memory model attached.
module tb_mem_access_stage;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    bit          clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_we, ex_re;
    logic [15:0] ex_addr, ex_wdata;
    logic [3:0]  ex_rd;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;
    logic        wb_valid, wb_ready, wb_is_load, wb_err;
    logic [15:0] wb_data;
    logic [3:0]  wb_rd;

    int n_cmp = 0;
    int n_bad = 0;
    int base;

    logic [15:0] mem [256];
    bit          preloaded = 1'b0;
    int          wr_cnt = 0;

    initial forever #5 clk = ~clk;

    mem_access_stage dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ex_valid_i        (ex_valid),
        .ex_ready_o        (ex_ready),
        .ex_addr_i         (ex_addr),
        .ex_wdata_i        (ex_wdata),
        .ex_we_i           (ex_we),
        .ex_re_i           (ex_re),
        .ex_rd_i           (ex_rd),
        .mem_access_addr_o (mem_access_addr),
        .mem_write_data_o  (mem_write_data),
        .mem_write_en_o    (mem_write_en),
        .mem_read_o        (mem_read),
        .mem_read_data_i   (mem_read_data),
        .wb_valid_o        (wb_valid),
        .wb_ready_i        (wb_ready),
        .wb_data_o         (wb_data),
        .wb_rd_o           (wb_rd),
        .wb_is_load_o      (wb_is_load),
        .wb_err_o          (wb_err)
    );

    // Data_Memory: synchronous write, combinational read, zero when not reading.
    always @(posedge clk) begin
        if (!preloaded) begin
            mem[5]  <= 16'h00AA;
            mem[7]  <= 16'h5555;
            mem[9]  <= 16'h0000;
            mem[10] <= 16'h1111;
            mem[11] <= 16'h2222;
            mem[12] <= 16'h3333;
            preloaded <= 1'b1;
        end
        if (mem_write_en) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_access_addr[15:8] == 8'h00)
                mem[mem_access_addr[7:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = (mem_read && mem_access_addr[15:8] == 8'h00)
                           ? mem[mem_access_addr[7:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic re,
                           input logic [15:0] a, input logic [15:0] wd, input logic [3:0] rd);
        ex_valid = v;
        ex_we    = we;
        ex_re    = re;
        ex_addr  = a;
        ex_wdata = wd;
        ex_rd    = rd;
    endtask

    initial begin
        rst = 1'b1;
        wb_ready = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        step();
        step();
        check("rst_ex_ready", 32'(ex_ready), 1);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_wen", 32'(mem_write_en), 0);
        check("rst_mread", 32'(mem_read), 0);
        check("rst_wb_data", 32'(wb_data), 0);
        check("rst_wb_err", 32'(wb_err), 0);
        rst = 1'b0;
        step();

        // simple load
        set_req(1'b1, 1'b0, 1'b1, 16'd5, 16'h0, 4'd3);
        step();
        check("t1_mread", 32'(mem_read), 1);
        check("t1_addr", 32'(mem_access_addr), 5);
        check("t1_ex_ready", 32'(ex_ready), 0);
        check("t1_wb_valid_acc", 32'(wb_valid), 0);
        ex_valid = 1'b0;
        step();
        check("t1_wb_valid", 32'(wb_valid), 1);
        check("t1_wb_data", 32'(wb_data), 32'h00AA);
        check("t1_wb_rd", 32'(wb_rd), 3);
        check("t1_is_load", 32'(wb_is_load), 1);
        check("t1_mread_off", 32'(mem_read), 0);
        check("t1_ex_ready_resp", 32'(ex_ready), 1);
        step();
        check("t1_idle_valid", 32'(wb_valid), 0);

        // store then load back
        base = wr_cnt;
        set_req(1'b1, 1'b1, 1'b0, 16'd9, 16'h1234, 4'd0);
        step();
        check("t2_wen", 32'(mem_write_en), 1);
        check("t2_wdata", 32'(mem_write_data), 32'h1234);
        ex_valid = 1'b0;
        step();
        check("t2_wb_valid", 32'(wb_valid), 1);
        check("t2_is_load", 32'(wb_is_load), 0);
        check("t2_wb_data", 32'(wb_data), 0);
        check("t2_wen_off", 32'(mem_write_en), 0);
        step();
        set_req(1'b1, 1'b0, 1'b1, 16'd9, 16'h0, 4'd4);
        step();
        ex_valid = 1'b0;
        step();
        check("t2_load_data", 32'(wb_data), 32'h1234);
        check("t2_load_rd", 32'(wb_rd), 4);
        check("t2_write_count", wr_cnt - base, 1);
        step();

        // WB backpressure
        wb_ready = 1'b0;
        set_req(1'b1, 1'b0, 1'b1, 16'd5, 16'h0, 4'd7);
        step();
        ex_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_valid", 32'(wb_valid), 1);
            check("t3_hold_data", 32'(wb_data), 32'h00AA);
            check("t3_hold_rd", 32'(wb_rd), 7);
            check("t3_ex_ready", 32'(ex_ready), 0);
            check("t3_no_strobe", 32'(mem_read | mem_write_en), 0);
            step();
        end
        wb_ready = 1'b1;
        #1;
        check("t3_ex_ready_rel", 32'(ex_ready), 1);
        step();
        check("t3_done", 32'(wb_valid), 0);

        // back-to-back loads with ex_valid held
        set_req(1'b1, 1'b0, 1'b1, 16'd10, 16'h0, 4'd1);
        step();
        check("t4_acc0", 32'(mem_read), 1);
        set_req(1'b1, 1'b0, 1'b1, 16'd11, 16'h0, 4'd2);
        step();
        check("t4_r0_data", 32'(wb_data), 32'h1111);
        check("t4_r0_rd", 32'(wb_rd), 1);
        check("t4_r0_ready", 32'(ex_ready), 1);
        step();
        check("t4_acc1", 32'(mem_access_addr), 11);
        check("t4_acc1_valid", 32'(wb_valid), 0);
        set_req(1'b1, 1'b0, 1'b1, 16'd12, 16'h0, 4'd3);
        step();
        check("t4_r1_data", 32'(wb_data), 32'h2222);
        check("t4_r1_rd", 32'(wb_rd), 2);
        step();
        ex_valid = 1'b0;
        step();
        check("t4_r2_data", 32'(wb_data), 32'h3333);
        check("t4_r2_rd", 32'(wb_rd), 3);
        step();
        check("t4_idle", 32'(wb_valid), 0);

        // we and re together: store only
        base = wr_cnt;
        set_req(1'b1, 1'b1, 1'b1, 16'd5, 16'h00BB, 4'd2);
        step();
        check("t5_wen", 32'(mem_write_en), 1);
        check("t5_no_read", 32'(mem_read), 0);
        ex_valid = 1'b0;
        step();
        check("t5_valid", 32'(wb_valid), 1);
        check("t5_is_load", 32'(wb_is_load), 0);
        check("t5_data", 32'(wb_data), 0);
        step();
        check("t5_mem5", 32'(mem[5]), 32'h00BB);
        check("t5_wr_count", wr_cnt - base, 1);

        // no-op request
        base = wr_cnt;
        set_req(1'b1, 1'b0, 1'b0, 16'd5, 16'hFFFF, 4'd6);
        step();
        check("t6_no_strobe", 32'(mem_read | mem_write_en), 0);
        ex_valid = 1'b0;
        step();
        check("t6_valid", 32'(wb_valid), 1);
        check("t6_is_load", 32'(wb_is_load), 0);
        check("t6_rd", 32'(wb_rd), 6);
        step();
        check("t6_wr_count", wr_cnt - base, 0);

        // reset during ACCESS of a store
        set_req(1'b1, 1'b1, 1'b0, 16'd7, 16'hDEAD, 4'd0);
        step();
        rst = 1'b1;
        ex_valid = 1'b0;
        #1;
        check("t7_wen_gated", 32'(mem_write_en), 0);
        step();
        check("t7_mem7", 32'(mem[7]), 32'h5555);
        check("t7_wb_valid", 32'(wb_valid), 0);
        rst = 1'b0;
        step();
        check("t7_idle_ready", 32'(ex_ready), 1);
        check("t7_idle_valid", 32'(wb_valid), 0);

        // out-of-range store
        base = wr_cnt;
        set_req(1'b1, 1'b1, 1'b0, 16'd300, 16'h4321, 4'd1);
        step();
        check("t8_wen", 32'(mem_write_en), 32'(1 - CHK));
        ex_valid = 1'b0;
        step();
        check("t8_valid", 32'(wb_valid), 1);
        check("t8_err", 32'(wb_err), 32'(CHK));
        check("t8_data", 32'(wb_data), 0);
        check("t8_is_load", 32'(wb_is_load), 0);
        step();
        check("t8_wr_count", wr_cnt - base, 1 - CHK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
